// File: rtl/multi_sequence_generator.sv
// multi_sequence_generator: streams {pad, fix, cnt} candidates over runtime ranges,
// with start/abort control, ready/valid backpressure, last flag and a word count.
module multi_sequence_generator #(
    parameter int SEQ_WIDTH  = 8,
    parameter int FIX_WIDTH  = 2,
    parameter int PAD_WIDTH  = 2,
    parameter int WCNT_WIDTH = 32,
    localparam int CNT_W     = SEQ_WIDTH - FIX_WIDTH - PAD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [CNT_W-1:0]      i_cnt_first,
    input  logic [CNT_W-1:0]      i_cnt_last,
    input  logic [FIX_WIDTH-1:0]  i_fix_first,
    input  logic [FIX_WIDTH-1:0]  i_fix_last,
    input  logic                  i_ready,
    output logic [SEQ_WIDTH-1:0]  o_seq,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [WCNT_WIDTH-1:0] o_words
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_first, cnt_last;
    logic [FIX_WIDTH-1:0]  fix, fix_nxt, fix_last;
    logic                  err, err_nxt, bad_range, at_cnt, at_fix, launch, xfer;
    logic [WCNT_WIDTH-1:0] words;

    assign at_cnt    = cnt == cnt_last;
    assign at_fix    = fix == fix_last;
    assign launch    = (state == IDLE) && i_start;
    assign xfer      = (state == RUN) && i_ready;
    assign bad_range = (i_cnt_first > i_cnt_last) || (i_fix_first > i_fix_last);

    // Equality is tested before incrementing, so all-ones limits never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fix_nxt   = fix;
        err_nxt   = err;
        if (state == IDLE) begin
            if (i_start) begin
                state_nxt = bad_range ? DONE : RUN;
                err_nxt   = bad_range;
                cnt_nxt   = i_cnt_first;
                fix_nxt   = i_fix_first;
            end
        end else if (state == RUN) begin
            if (i_abort) begin
                state_nxt = IDLE;
            end else if (i_ready) begin
                cnt_nxt   = at_cnt ? cnt_first : cnt + 1'b1;
                fix_nxt   = (at_cnt && !at_fix) ? fix + 1'b1 : fix;
                state_nxt = (at_cnt && at_fix) ? DONE : RUN;
            end
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fix       <= '0;
            err       <= 1'b0;
            cnt_first <= '0;
            cnt_last  <= '0;
            fix_last  <= '0;
            words     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fix   <= fix_nxt;
            err   <= err_nxt;
            if (launch) begin
                cnt_first <= i_cnt_first;
                cnt_last  <= i_cnt_last;
                fix_last  <= i_fix_last;
            end
            // An aborted cycle's transfer still counts: the sink sampled it.
            if (launch)
                words <= '0;
            else if (xfer && !(&words))
                words <= words + 1'b1;
        end
    end

    assign o_valid = state == RUN;
    assign o_busy  = state != IDLE;
    assign o_done  = state == DONE;
    assign o_err   = (state == DONE) && err;
    assign o_last  = o_valid && at_cnt && at_fix;
    assign o_seq   = o_valid ? {{PAD_WIDTH{1'b0}}, fix, cnt} : '0;
    assign o_words = words;
endmodule
